// File: rtl/encoder4to2_arb_pkg.sv
// rtl/encoder4to2_arb_pkg.sv - shared constants for the 4-to-2 arbitrating encoder
package encoder4to2_arb_pkg;

    localparam int SRC_N  = 4;
    localparam int CODE_W = 2;

    // Last-granted pointer value out of reset, so the first search starts at source 0.
    localparam logic [CODE_W-1:0] RR_RESET = 2'd3;

endpackage

// File: rtl/encoder4to2_arb_prienc.sv
// rtl/encoder4to2_arb_prienc.sv - rotating priority encoder, search begins at start
module prienc4to2
    import encoder4to2_arb_pkg::*;
(
    input  logic [SRC_N-1:0]  vec,
    input  logic [CODE_W-1:0] start,
    output logic [CODE_W-1:0] code,
    output logic              any
);

    logic [CODE_W-1:0] idx;

    // Walk from the farthest offset back to start so the nearest set bit wins.
    always_comb begin
        code = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = SRC_N - 1; k >= 0; k--) begin
            idx = start + CODE_W'(k);
            if (vec[idx]) begin
                code = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder4to2_arb.sv
// rtl/encoder4to2_arb.sv - pending-request encoder with ready/valid output; ENC_ROUND_ROBIN_EN selects round-robin
module encoder4to2_arb
    import encoder4to2_arb_pkg::*;
#(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SRC_N-1:0]  req,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt
);

    logic [SRC_N-1:0]  pend;
    logic [SRC_N-1:0]  clr;
    logic [CODE_W-1:0] start;
    logic [CODE_W-1:0] sel;
    logic              any;
    logic              grant;
    logic              drop;

`ifdef ENC_ROUND_ROBIN_EN
    logic [CODE_W-1:0] rr_ptr;

    assign start = rr_ptr + CODE_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= RR_RESET;
        end else if (grant) begin
            rr_ptr <= sel;
        end
    end
`else
    assign start = '0;
`endif

    prienc4to2 u_prienc (
        .vec   (pend),
        .start (start),
        .code  (sel),
        .any   (any)
    );

    assign grant = any && (!out_valid || out_ready);
    assign clr   = grant ? (SRC_N'(1) << sel) : '0;
    // A new pulse on the bit being granted re-arms it rather than counting as a drop.
    assign drop  = |(req & pend & ~clr);
    assign busy  = (|pend) || out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            drop_cnt  <= '0;
        end else begin
            pend <= (pend & ~clr) | req;
            if (grant) begin
                out_valid <= 1'b1;
                out_code  <= sel;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

endmodule
